// File: rtl/mvm_argmax_reduce_if.sv
// Streaming ports of the argmax reducer: FP16 input beats in, packed argmax index words out.
interface mvm_argmax_reduce_if #(
   parameter int AXI_DW = 512
);
   logic              in_valid;
   logic              in_ready;
   logic [AXI_DW-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [AXI_DW-1:0] out_data;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/mvm_argmax_reduce.sv
// Per-token running argmax over channel-group-major FP16 beats; emits packed argmax
// channel indices, TOUT per word, once every group has been folded in.
module mvm_argmax_lane #(
   parameter int DAT_DW = 16,
   parameter int CBW    = 21,
   parameter int LANE   = 0
)(
   input  logic [DAT_DW-1:0] data,
   input  logic [CBW-1:0]    ch_base,
   input  logic [15:0]       ch_valid,
   output logic [DAT_DW:0]   key
);
   logic [CBW-1:0]    ch;
   logic [DAT_DW-1:0] ord;

   assign ch  = ch_base + CBW'(LANE);
   assign ord = data[DAT_DW-1] ? ~data : {1'b1, data[DAT_DW-2:0]};
   // MSB marks a real channel, so padding ranks below every real value (even -NaN)
   assign key = (ch < CBW'(ch_valid)) ? {1'b1, ord} : '0;
endmodule

module mvm_argmax_reduce #(
   parameter int TOUT      = 32,
   parameter int DAT_DW    = 16,
   parameter int IDX_DW    = 16,
   parameter int MAX_TOKEN = 128,
   parameter int AXI_DW    = TOUT * DAT_DW
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [15:0]          cfg_token,
   input  logic [15:0]          cfg_ch_groups,
   input  logic [15:0]          cfg_ch_valid,
   mvm_argmax_reduce_if.slave   bus,
   output logic                 busy,
   output logic                 done
);
   localparam int LW     = $clog2(TOUT);
   localparam int KW     = DAT_DW + 1;
   localparam int TW     = $clog2(MAX_TOKEN);
   localparam int TCW    = $clog2(MAX_TOKEN + 1);
   localparam int CBW    = 16 + LW;
   localparam int STAGES = 2;

   typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [KW-1:0]     key;
      logic [IDX_DW-1:0] ch;
   } ent_t;

   typedef struct packed {
      ent_t          cand;
      ent_t          old;
      logic [TW-1:0] t;
      logic          first;
   } s1_t;

   typedef struct packed {
      ent_t          ent;
      logic [TW-1:0] t;
   } wr_t;

   state_t                  state, state_nxt;
   logic [TCW-1:0]          tok_q, t_cnt, w_cnt, n_words;
   logic [TCW:0]            nw_sum;
   logic [15:0]             grp_q, chv_q, g_cnt;
   logic                    fl_cnt, acc, last_acc, out_hs;
   logic [STAGES:1]         vld_pipe;
   s1_t                     s1;
   wr_t                     wr;
   ent_t                    store [MAX_TOKEN];
   ent_t                    old_ent, res_ent;
   logic [TOUT-1:0][KW-1:0] lane_key;
   logic [KW-1:0]           red_key;
   logic [LW-1:0]           red_lane;
   logic [AXI_DW-1:0]       word_nxt;
   logic [CBW-1:0]          ch_base;

   assign ch_base  = {g_cnt, {LW{1'b0}}};
   assign acc      = bus.in_valid && (state == S_ACCUM);
   assign last_acc = acc && (t_cnt == tok_q - 1'b1) && (g_cnt == grp_q - 1'b1);
   assign out_hs   = bus.out_valid && bus.out_ready;
   assign nw_sum   = {1'b0, tok_q} + (TCW+1)'(TOUT - 1);
   assign n_words  = TCW'(nw_sum >> LW);

   for (genvar l = 0; l < TOUT; l++) begin : g_lane
      mvm_argmax_lane #(.DAT_DW(DAT_DW), .CBW(CBW), .LANE(l)) u_lane (
         .data     (bus.in_data[l*DAT_DW +: DAT_DW]),
         .ch_base  (ch_base),
         .ch_valid (chv_q),
         .key      (lane_key[l])
      );
   end

   // Pairwise tree; the left operand always holds lower lanes, so ties stay left
   always_comb begin : p_tree
      logic [KW-1:0] rk [TOUT];
      logic [LW-1:0] rl [TOUT];
      for (int i = 0; i < TOUT; i++) begin
         rk[i] = lane_key[i];
         rl[i] = LW'(i);
      end
      for (int lv = 0; lv < LW; lv++) begin
         for (int i = 0; i < TOUT; i += (2 << lv)) begin
            if (rk[i + (1 << lv)] > rk[i]) begin
               rk[i] = rk[i + (1 << lv)];
               rl[i] = rl[i + (1 << lv)];
            end
         end
      end
      red_key  = rk[0];
      red_lane = rl[0];
   end

   // Stage 1 reads the store at accept time, which misses the write landing on
   // the same edge; the registered copy of that write is forwarded here instead.
   always_comb begin
      old_ent = s1.old;
      if (vld_pipe[2] && (wr.t == s1.t))
         old_ent = wr.ent;
      res_ent = old_ent;
      if (s1.first || (s1.cand.key > old_ent.key))
         res_ent = s1.cand;
   end

   always_comb begin : p_word
      logic [TCW+LW-1:0] tix;
      word_nxt = '0;
      for (int k = 0; k < TOUT; k++) begin
         tix = {w_cnt, LW'(k)};
         if (tix < (TCW+LW)'(tok_q))
            word_nxt[k*IDX_DW +: IDX_DW] = store[tix[TW-1:0]].ch;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      bus.in_ready = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start)
               state_nxt = (cfg_token == '0 || cfg_ch_groups == '0) ? S_DONE : S_ACCUM;
         end
         S_ACCUM: begin
            bus.in_ready = 1'b1;
            if (last_acc) state_nxt = S_FLUSH;
         end
         S_FLUSH: if (fl_cnt) state_nxt = S_DRAIN;
         S_DRAIN: if (out_hs && bus.out_last) state_nxt = S_DONE;
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_q         <= '0;
         grp_q         <= '0;
         chv_q         <= '0;
         t_cnt         <= '0;
         g_cnt         <= '0;
         w_cnt         <= '0;
         fl_cnt        <= 1'b0;
         vld_pipe      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            tok_q <= (cfg_token > 16'(MAX_TOKEN)) ? TCW'(MAX_TOKEN) : TCW'(cfg_token);
            grp_q <= cfg_ch_groups;
            chv_q <= cfg_ch_valid;
            t_cnt <= '0;
            g_cnt <= '0;
            w_cnt <= '0;
         end
         if (acc) begin
            if (t_cnt == tok_q - 1'b1) begin
               t_cnt <= '0;
               g_cnt <= g_cnt + 1'b1;
            end else begin
               t_cnt <= t_cnt + 1'b1;
            end
         end
         fl_cnt   <= (state == S_FLUSH) && !fl_cnt;
         vld_pipe <= {vld_pipe[STAGES-1:1], acc};
         if (state == S_DRAIN && (!bus.out_valid || bus.out_ready)) begin
            if (w_cnt < n_words) begin
               bus.out_valid <= 1'b1;
               bus.out_data  <= word_nxt;
               bus.out_last  <= (w_cnt == n_words - 1'b1);
               w_cnt         <= w_cnt + 1'b1;
            end else begin
               bus.out_valid <= 1'b0;
               bus.out_data  <= '0;
               bus.out_last  <= 1'b0;
            end
         end
      end
   end

   // Datapath registers and the running-max store carry no reset
   always_ff @(posedge clk) begin
      if (acc) begin
         s1.cand.key <= red_key;
         s1.cand.ch  <= IDX_DW'({g_cnt, red_lane});
         s1.old      <= store[t_cnt[TW-1:0]];
         s1.t        <= t_cnt[TW-1:0];
         s1.first    <= (g_cnt == '0);
      end
      if (vld_pipe[1]) begin
         store[s1.t] <= res_ent;
         wr.ent      <= res_ent;
         wr.t        <= s1.t;
      end
   end
endmodule

// File: tb/tb_mvm_argmax_reduce.sv
// Directed-vector bench for mvm_argmax_reduce with a queue scoreboard and an
// independent output monitor.
module tb_mvm_argmax_reduce;
   localparam int TOUT   = 32;
   localparam int DW     = 16;
   localparam int AXI_DW = TOUT * DW;

   typedef struct {
      logic [AXI_DW-1:0] data;
      logic              last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_token = '0, cfg_ch_groups = '0, cfg_ch_valid = '0;
   logic        busy, done;
   logic        bp_mode = 1'b0;
   int          n_chk = 0, n_err = 0, ov_seen = 0;
   exp_t        exp_q[$];

   mvm_argmax_reduce_if #(.AXI_DW(AXI_DW)) bus();

   mvm_argmax_reduce #(.TOUT(TOUT), .DAT_DW(DW), .IDX_DW(DW), .MAX_TOKEN(128)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_token     (cfg_token),
      .cfg_ch_groups (cfg_ch_groups),
      .cfg_ch_valid  (cfg_ch_valid),
      .bus           (bus),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [AXI_DW-1:0] act, input logic [AXI_DW-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   // Stimulus patterns: value of channel ch of token t for each job
   function automatic logic [15:0] val(int job, int t, int ch);
      case (job)
         1: begin
            if (ch == (t*37 + 5) % 512)      return 16'h4200;
            if (ch == (t*37 + 6) % 512)      return 16'h4000;
            return 16'hBC00;
         end
         2: begin
            if (t == 0) return (ch == 300 || ch == 40) ? 16'h4000 : 16'h3C00;
            if (ch < 77)  return 16'h8000;
            if (ch == 77) return 16'h0000;
            return (ch % 2 == 1) ? 16'h8000 : 16'h0000;
         end
         3: begin
            if (ch == 505)              return 16'h7BFF;
            if (ch == 510)              return 16'h7C00;
            if (t == 0 && ch == 499)    return 16'hBC00;
            if (t == 1 && ch == 250)    return 16'hB800;
            return 16'hC500;
         end
         4: begin
            if (ch == 103) return 16'h4400;
            if (ch == 70)  return 16'h4200;
            if (ch == 40)  return 16'h4000;
            if (ch == 2)   return 16'h3C00;
            return 16'hBC00;
         end
         5: begin
            if (ch == 5)   return 16'h7000;
            if (ch == 40)  return 16'h4000;
            if (ch == 70)  return 16'h4200;
            if (ch == 103) return 16'h6000;
            return 16'hBC00;
         end
         6: begin
            if (ch == (t*3) % 64) return 16'h5000;
            if (ch == t % 64)     return 16'h4C00;
            return 16'hC000;
         end
         8: return (ch == (t + 1) * 20) ? 16'h4800 : 16'h3800;
         9: return (ch == t % 32) ? 16'h4000 : 16'h0000;
         default: return 16'h3C00;
      endcase
   endfunction

   // Hand-derived argmax channel per token for each job
   function automatic int exp_idx(int job, int t);
      case (job)
         1: return (t*37 + 5) % 512;
         2: return (t == 0) ? 40 : 77;
         3: return (t == 0) ? 499 : (t == 1) ? 250 : 0;
         4: return 103;
         5: return 5;
         6: return (t*3) % 64;
         8: return (t + 1) * 20;
         9: return t % 32;
         default: return 0;
      endcase
   endfunction

   function automatic logic [AXI_DW-1:0] beat(int job, int t, int g);
      logic [AXI_DW-1:0] b;
      b = '0;
      for (int l = 0; l < TOUT; l++) b[l*DW +: DW] = val(job, t, g*TOUT + l);
      return b;
   endfunction

   task automatic run_job(input int job, input int tok, input int grp, input int chv, input bit gaps);
      int   ntok, nw;
      bit   got, dn;
      exp_t e;
      ntok = (tok > 128) ? 128 : tok;
      if (ntok > 0 && grp > 0) begin
         nw = (ntok + TOUT - 1) / TOUT;
         for (int w = 0; w < nw; w++) begin
            e.data = '0;
            for (int k = 0; k < TOUT; k++)
               if (w*TOUT + k < ntok) e.data[k*DW +: DW] = 16'(exp_idx(job, w*TOUT + k));
            e.last = (w == nw - 1);
            exp_q.push_back(e);
         end
      end
      ov_seen = 0;
      @(posedge clk); #1;
      start = 1'b1; cfg_token = 16'(tok); cfg_ch_groups = 16'(grp); cfg_ch_valid = 16'(chv);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("in_ready_after_start", bus.in_ready, (ntok > 0 && grp > 0));
      if (ntok > 0 && grp > 0) begin
         for (int g = 0; g < grp; g++) begin
            for (int t = 0; t < ntok; t++) begin
               if (gaps && $urandom_range(0, 3) == 0) begin
                  bus.in_valid = 1'b0;
                  @(posedge clk); #1;
               end
               bus.in_valid = 1'b1;
               bus.in_data  = beat(job, t, g);
               got = 1'b0;
               for (int c = 0; c < 100 && !got; c++) begin
                  @(negedge clk);
                  got = bus.in_ready;
                  @(posedge clk); #1;
               end
               if (!got) begin
                  n_chk++; n_err++;
                  $display("FAIL in_accept: beat g=%0d t=%0d not accepted within 100 cycles", g, t);
               end
            end
         end
         bus.in_valid = 1'b0;
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk("out_valid_during_flush", bus.out_valid, 0);
         @(posedge clk); #1;
         chk("out_valid_3_after_last", bus.out_valid, 1);
      end
      dn = 1'b0;
      for (int c = 0; c < 3000 && !dn; c++) begin
         @(negedge clk);
         dn = done;
      end
      chk("done_seen", dn, 1);
      @(posedge clk); #1;
      chk("busy_after_done", busy, 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      if (ntok == 0 || grp == 0) chk("degenerate_no_out_valid", ov_seen, 0);
   endtask

   // Downstream ready: always ready, or random backpressure
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: pops the scoreboard on every handshake
   initial begin
      logic              stall_q, done_due;
      logic [AXI_DW-1:0] stall_d;
      logic              stall_l;
      exp_t              e;
      stall_q = 1'b0; done_due = 1'b0; stall_d = '0; stall_l = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_q  = 1'b0;
            done_due = 1'b0;
         end else begin
            if (done_due) begin
               chk("done_1_after_last_hs", done, 1);
               done_due = 1'b0;
            end
            if (stall_q) begin
               chk("stall_valid_held", bus.out_valid, 1);
               chk("stall_data_held", bus.out_data, stall_d);
               chk("stall_last_held", bus.out_last, stall_l);
            end
            if (bus.out_valid) ov_seen++;
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++; n_err++;
                  $display("FAIL unexpected_word: got %h want no word", bus.out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", bus.out_data, e.data);
                  chk("out_last", bus.out_last, e.last);
                  if (bus.out_last) done_due = 1'b1;
               end
            end
            stall_q = bus.out_valid && !bus.out_ready;
            stall_d = bus.out_data;
            stall_l = bus.out_last;
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;

      run_job(1, 37, 16, 512, 1'b0);
      run_job(2, 2, 16, 512, 1'b0);
      run_job(3, 3, 16, 500, 1'b1);
      run_job(4, 1, 4, 128, 1'b0);
      run_job(5, 1, 4, 128, 1'b0);
      bp_mode = 1'b1;
      run_job(6, 64, 2, 64, 1'b1);
      bp_mode = 1'b0;
      run_job(0, 0, 4, 512, 1'b0);
      run_job(0, 5, 0, 512, 1'b0);

      // Abort a job mid-accumulation
      @(posedge clk); #1;
      start = 1'b1; cfg_token = 16'd5; cfg_ch_groups = 16'd4; cfg_ch_valid = 16'd128;
      @(posedge clk); #1;
      start = 1'b0;
      bus.in_valid = 1'b1;
      for (int b = 0; b < 6; b++) begin
         bus.in_data = beat(7, b % 5, b / 5);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #2;
      chk("abort_in_ready", bus.in_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_out_last", bus.out_last, 0);
      chk("abort_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_job(8, 3, 4, 128, 1'b0);
      run_job(9, 300, 1, 32, 1'b0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mvm_argmax_reduce.md
# mvm_argmax_reduce

Downstream consumer of the HBM MVM + BN + residual-add datapath. It accepts the Tout-lane FP16 output stream in channel-group-major order and keeps a per-token running maximum across all channel groups. After the last group it emits each token's argmax channel index, packed Tout indices per AXI-width word, for writeback to the Argmax output buffer.

## Interface
- TOUT, 32, lanes per input beat and indices per output word
- DAT_DW, 16, element width (FP16)
- IDX_DW, 16, width of one packed argmax index
- MAX_TOKEN, 128, token capacity of the running-max store
- AXI_DW, TOUT*DAT_DW, input/output word width (512)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a job (ignored unless IDLE)
- cfg_token  in  16  tokens per job (Win), 0..MAX_TOKEN
- cfg_ch_groups  in  16  channel groups per job (CHout_div_Tout)
- cfg_ch_valid  in  16  real channel count (CHout); channels ≥ this are padding
- in_valid  in  1  input beat valid
- in_ready  out  1  high only in ACCUM
- in_data  in  AXI_DW  lane l = channel g*TOUT+l of current token, FP16
- out_valid  out  1  packed index word valid
- out_ready  in  1  downstream accept
- out_data  out  AXI_DW  lane k (IDX_DW bits) = argmax of token w*TOUT+k
- out_last  out  1  marks final output word, qualified by out_valid
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE → ACCUM → FLUSH → DRAIN → DONE → IDLE.
- Input order: for g in 0..cfg_ch_groups-1, for t in 0..cfg_token-1, one beat. Counters t and g; t wraps to 0 and g increments after each token sweep.
- Compare key: FP16 mapped to unsigned by inverting all bits when sign=1, else flipping the sign bit. Larger key = larger value, so -0 < +0 and NaNs order by the same rule.
- Padding mask: a lane whose channel is ≥ cfg_ch_valid gets key 0, and that lane is never chosen.
- Per beat: a TOUT-lane reduction tree yields (max_key, lane). Ties go to the lowest lane. Stage 1 registers this result with channel index g*TOUT+lane.
- Stage 2 does read-modify-write of store[t]. Group 0 writes unconditionally. Later groups replace only if the new key is strictly greater, so ties keep the earlier (lower) channel.
- Back-to-back beats to the same token (cfg_token==1) must forward the stage-2 result into the next compare. A missed update is a bug.
- ACCUM ends after beat (cfg_ch_groups-1, cfg_token-1) is accepted. FLUSH waits 2 cycles for the pipeline to empty.
- DRAIN emits ceil(cfg_token/TOUT) words. Lanes of the final word beyond cfg_token are zero. out_last is high on the final word.
- A valid-ready handshake on the final word moves to DONE. DONE pulses done for 1 cycle, then returns to IDLE and deasserts busy.
- Degenerate configs: start with cfg_token==0 or cfg_ch_groups==0 goes straight to DONE. No input is accepted and no output word is emitted.
- cfg_token > MAX_TOKEN is clamped to MAX_TOKEN.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, state=IDLE, counters=0. The store contents are don't-care.
- start sampled in IDLE: busy=1 and in_ready=1 from the next cycle.
- The accumulator accepts one beat per cycle with no bubbles while in_valid=1.
- Accept to store update: 2 cycles.
- Last accept to first out_valid: 3 cycles (2-cycle FLUSH plus DRAIN entry).
- Output handshake: out_data and out_last are held stable while out_valid=1 and out_ready=0. Up to one word per cycle is sent.
- Final output handshake to done pulse: 1 cycle.
- Asynchronous reset mid-job aborts immediately: all outputs return to reset values and no further words are emitted.
- in_valid during IDLE, FLUSH or DRAIN is not accepted (in_ready=0).

## Test plan
- Basic job: cfg_token=37, cfg_ch_groups=16, cfg_ch_valid=512, random FP16 input → 2 words. Indices match a software argmax. Word 1 lanes 5..31 are 0. out_last is on word 1.
- Ties and sign: all values +1.0 except channels 300 and 40 = +2.0 → index 40. Token whose channels are all -0/+0 mixed → index of the first +0.
- Padding: cfg_ch_valid=500, cfg_ch_groups=16, channel 505 = 65504 and the others negative → index is the max among 0..499, never ≥ 500.
- Hazard: cfg_token=1, cfg_ch_groups=4, max in group 3 lane 7, no in_valid gaps → index 103.
- Backpressure: cfg_token=64 with out_ready toggled randomly → 2 words. Data stays stable while stalled. done fires exactly 1 cycle after the second handshake.
- Reset and degenerate cases: assert rst_n low mid-ACCUM, then run a fresh job → correct result. cfg_token=0 → done with no out_valid.
